seq_divider_stage: RTL and testbench



---
 rtl/seq_divider_stage_if.sv | 27 ++
 rtl/seq_divider_stage.sv | 142 ++++++++++++++
 tb/tb_seq_divider_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_stage_if.sv
`timescale 1ns/1ps
// Operand/result handshake bundle for the sequential divider stage.
// slave = divider side, master = producer/consumer side.
interface seq_divider_stage_if #(
    parameter int WIDTH = 10
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_zero;
    logic             o_busy;

    modport slave (
        input  i_valid, i_dividend, i_divisor, i_ready,
        output o_ready, o_valid, o_quotient, o_remainder, o_div_zero, o_busy
    );

    modport master (
        output i_valid, i_dividend, i_divisor, i_ready,
        input  o_ready, o_valid, o_quotient, o_remainder, o_div_zero, o_busy
    );
endinterface

// File: rtl/seq_divider_stage.sv
`timescale 1ns/1ps
// Restoring shift-subtract unsigned divider, one quotient bit per cycle.
// Latency WIDTH+1 cycles from accept to o_valid (1 cycle for a zero divisor).
// Result held in DONE until i_ready; no new operands accepted until then.
module seq_divider_stage #(
    parameter int WIDTH = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    seq_divider_stage_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             w_ready;
    logic             w_valid;
    logic             w_busy;

    // r_dq starts as the dividend; quotient bits shift into its vacated LSBs.
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_o_quot;
    logic [WIDTH-1:0] r_o_rem;
    logic             r_o_dz;

    logic [WIDTH:0]   w_t;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nx;
    logic             w_last;

    // Partial remainder stays below the divisor, so its extra top bit is always
    // zero and is not stored; a clear borrow out of the subtract means t >= divisor.
    assign w_t      = {r_rem, r_dq[WIDTH-1]};
    assign w_diff   = w_t - {1'b0, r_div};
    assign w_qbit   = ~w_diff[WIDTH];
    assign w_rem_nx = w_qbit ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
    assign w_last   = (r_cnt == LAST_ITER);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ready    = 1'b0;
        w_valid    = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_ready = ~i_rst;
                w_busy  = 1'b0;
                if (bus.i_valid) begin
                    w_state_nx = (bus.i_divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_valid = 1'b1;
                if (bus.i_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dq     <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_o_quot <= '0;
            r_o_rem  <= '0;
            r_o_dz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        r_dq  <= bus.i_dividend;
                        r_div <= bus.i_divisor;
                        r_rem <= '0;
                        r_cnt <= '0;
                        if (bus.i_divisor == '0) begin
                            r_o_quot <= '1;
                            r_o_rem  <= bus.i_dividend;
                            r_o_dz   <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_dq  <= {r_dq[WIDTH-2:0], w_qbit};
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_o_quot <= {r_dq[WIDTH-2:0], w_qbit};
                        r_o_rem  <= w_rem_nx;
                        r_o_dz   <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.i_ready) begin
                        r_o_quot <= '0;
                        r_o_rem  <= '0;
                        r_o_dz   <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.o_ready     = w_ready;
    assign bus.o_valid     = w_valid;
    assign bus.o_busy      = w_busy;
    assign bus.o_quotient  = r_o_quot;
    assign bus.o_remainder = r_o_rem;
    assign bus.o_div_zero  = r_o_dz;
endmodule

// File: tb/tb_seq_divider_stage.sv
`timescale 1ns/1ps
// Bench for seq_divider_stage: directed table, hand-written corner sequences
// and randomized operands against a plain-arithmetic reference.
module tb_seq_divider_stage;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_divider_stage_if #(.WIDTH(W)) bus ();

    seq_divider_stage #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered and left at a negedge. Returns result, latency in cycles after the
    // accept edge, and whether o_valid was ever seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] d, input int stall,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output int lat, output logic got);
        int k;
        k = 0;
        while (!bus.o_ready && k < 50) begin
            cyc();
            k++;
        end
        bus.i_valid    = 1'b1;
        bus.i_dividend = a;
        bus.i_divisor  = d;
        bus.i_ready    = (stall == 0);
        cyc();
        bus.i_valid = 1'b0;
        lat = 1;
        while (!bus.o_valid && lat < 50) begin
            cyc();
            lat++;
        end
        got = bus.o_valid;
        q   = bus.o_quotient;
        r   = bus.o_remainder;
        dz  = bus.o_div_zero;
        repeat (stall) cyc();
        bus.i_ready = 1'b1;
        cyc();
    endtask

    initial begin
        logic [W-1:0] q, r, a, d, eq, er;
        logic         dz, got, edz;
        int           lat, elat;

        tbl[0] = '{a: 10'd1000, d: 10'd7,    q: 10'd142,  r: 10'd6,  dz: 1'b0, lat: 11};
        tbl[1] = '{a: 10'd5,    d: 10'd9,    q: 10'd0,    r: 10'd5,  dz: 1'b0, lat: 11};
        tbl[2] = '{a: 10'd1023, d: 10'd1,    q: 10'd1023, r: 10'd0,  dz: 1'b0, lat: 11};
        tbl[3] = '{a: 10'd1023, d: 10'd1023, q: 10'd1,    r: 10'd0,  dz: 1'b0, lat: 11};
        tbl[4] = '{a: 10'd37,   d: 10'd0,    q: 10'd1023, r: 10'd37, dz: 1'b1, lat: 1};
        tbl[5] = '{a: 10'd200,  d: 10'd13,   q: 10'd15,   r: 10'd5,  dz: 1'b0, lat: 11};
        tbl[6] = '{a: 10'd0,    d: 10'd5,    q: 10'd0,    r: 10'd0,  dz: 1'b0, lat: 11};
        tbl[7] = '{a: 10'd512,  d: 10'd3,    q: 10'd170,  r: 10'd2,  dz: 1'b0, lat: 11};

        bus.i_valid    = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        bus.i_ready    = 1'b1;

        // Reset state
        repeat (3) cyc();
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_quot", bus.o_quotient, 0);
        chk("rst_rem", bus.o_remainder, 0);
        chk("rst_dz", bus.o_div_zero, 0);
        rst = 1'b0;
        cyc();
        chk("post_rst_ready", bus.o_ready, 1);

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].d, 0, q, r, dz, lat, got);
            chk("tbl_got", got, 1);
            chk("tbl_lat", lat, tbl[i].lat);
            chk("tbl_quot", q, tbl[i].q);
            chk("tbl_rem", r, tbl[i].r);
            chk("tbl_dz", dz, tbl[i].dz);
            chk("tbl_ready_after", bus.o_ready, 1);
        end

        // Backpressure with an ignored i_valid pulse during DONE
        bus.i_valid    = 1'b1;
        bus.i_dividend = 10'd1000;
        bus.i_divisor  = 10'd7;
        bus.i_ready    = 1'b0;
        cyc();
        bus.i_valid = 1'b0;
        lat = 1;
        while (!bus.o_valid && lat < 50) begin
            cyc();
            lat++;
        end
        chk("bp_lat", lat, 11);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.o_valid, 1);
            chk("bp_ready", bus.o_ready, 0);
            chk("bp_quot", bus.o_quotient, 142);
            chk("bp_rem", bus.o_remainder, 6);
            chk("bp_dz", bus.o_div_zero, 0);
            bus.i_valid    = (i == 1);
            bus.i_dividend = 10'd55;
            bus.i_divisor  = 10'd3;
            cyc();
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        cyc();
        chk("bp_release_valid", bus.o_valid, 0);
        chk("bp_release_ready", bus.o_ready, 1);
        run_op(10'd55, 10'd3, 0, q, r, dz, lat, got);
        chk("bp_next_lat", lat, 11);
        chk("bp_next_quot", q, 18);
        chk("bp_next_rem", r, 1);

        // Reset in CALC iteration 4
        bus.i_valid    = 1'b1;
        bus.i_dividend = 10'd1000;
        bus.i_divisor  = 10'd7;
        cyc();
        bus.i_valid = 1'b0;
        repeat (4) cyc();
        chk("mid_busy", bus.o_busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_busy", bus.o_busy, 0);
        chk("mrst_valid", bus.o_valid, 0);
        chk("mrst_quot", bus.o_quotient, 0);
        chk("mrst_rem", bus.o_remainder, 0);
        chk("mrst_ready", bus.o_ready, 1);
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            chk("mrst_no_stale", bus.o_valid, 0);
            cyc();
        end
        run_op(10'd200, 10'd13, 0, q, r, dz, lat, got);
        chk("mrst_next_lat", lat, 11);
        chk("mrst_next_quot", q, 15);
        chk("mrst_next_rem", r, 5);

        // Randomized back-to-back operations
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: a = 10'd0;
                1: a = 10'd1023;
                2: a = 10'd1;
                default: a = W'($urandom_range(0, 1023));
            endcase
            case ($urandom_range(0, 5))
                0: d = 10'd0;
                1: d = 10'd1023;
                2: d = 10'd1;
                default: d = W'($urandom_range(0, 1023));
            endcase
            if (d == 0) begin
                eq = '1; er = a; edz = 1'b1; elat = 1;
            end else begin
                eq = a / d; er = a % d; edz = 1'b0; elat = W + 1;
            end
            run_op(a, d, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   q, r, dz, lat, got);
            chk("rnd_got", got, 1);
            chk("rnd_lat", lat, elat);
            chk("rnd_quot", q, eq);
            chk("rnd_rem", r, er);
            chk("rnd_dz", dz, edz);
            if (d != 0) begin
                chk("rnd_identity", ((32'(q) * 32'(d) + 32'(r)) == 32'(a)) && (r < d), 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
